// File: rtl/qracc_pkg.sv
// Shared types and constants for the qracc bus initiator.
package qracc_pkg;

    localparam int QRACC_BUS_BYTES = 32 / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        DONE
    } qracc_state_e;

endpackage

// File: rtl/qracc_bus_initiator.sv
// Burst initiator on the qracc data interface: one command becomes len single-word transfers.
// Optional stall counter port enabled by defining QRACC_BUS_INIT_PERF_EN.
module qracc_bus_initiator
    import qracc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                busy,
    output logic                done
`ifdef QRACC_BUS_INIT_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int              BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);

    qracc_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hold_q, hold_d;
    logic              word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        hold_d    = hold_q;
        cmd_ready = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        bus_be    = '0;
        wr_ready  = 1'b0;
        word_done = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    write_d  = cmd_write;
                    state_d  = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                bus_be = '1;
                if (write_q) begin
                    // Writes are posted: the grant itself retires the word.
                    bus_req   = wr_valid;
                    bus_we    = 1'b1;
                    bus_wdata = wr_data;
                    wr_ready  = bus_gnt;
                    word_done = wr_valid && bus_gnt;
                end else begin
                    bus_req = 1'b1;
                    if (bus_gnt) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (!hold_q && bus_rvalid) begin
                    rdata_d = bus_rdata;
                    hold_d  = 1'b1;
                end
                if (hold_q && rd_ready) begin
                    hold_d    = 1'b0;
                    word_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (word_done) begin
            addr_d   = addr_q + ADDR_STEP;
            remain_d = remain_q - LEN_W'(1);
            state_d  = (remain_q == LEN_W'(1)) ? DONE : ISSUE;
        end
    end

    assign bus_addr = addr_q;
    assign rd_valid = hold_q;
    assign rd_data  = rdata_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

`ifdef QRACC_BUS_INIT_PERF_EN
    logic [31:0] stall_q;

    // Counts request cycles left ungranted; restarts with every new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            stall_q <= '0;
        end else if (bus_req && !bus_gnt && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_qracc_bus_initiator.sv
// Directed testbench for qracc_bus_initiator: write/read bursts, zero length, grant stall, wrap and reset.
module tb_qracc_bus_initiator;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        done;
`ifdef QRACC_BUS_INIT_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] wdata [4] = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003, 32'hF00D_0004};
    logic [31:0] rdata [3] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC};

    qracc_bus_initiator dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .done       (done)
`ifdef QRACC_BUS_INIT_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then step 1ns past the edge before driving.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_ready   = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        applyStimulus(2);
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_bus_we", bus_we, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        checkOutput("rst_bus_wdata", bus_wdata, 0);
        checkOutput("rst_bus_be", bus_be, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_done", done, 0);

        $display("[TB] write burst 0x100 len 4");
        applyStimulus(1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h100;
        cmd_len   = 16'd4;
        bus_gnt   = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = wdata[0];
        #1;
        checkOutput("wr_cmd_ready", cmd_ready, 1);
        checkOutput("wr_no_req_idle", bus_req, 0);
        applyStimulus(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data = wdata[i];
            #1;
            checkOutput("wr_bus_req", bus_req, 1);
            checkOutput("wr_bus_we", bus_we, 1);
            checkOutput("wr_bus_addr", bus_addr, 32'h100 + 32'(4 * i));
            checkOutput("wr_bus_wdata", bus_wdata, wdata[i]);
            checkOutput("wr_bus_be", bus_be, 4'hF);
            checkOutput("wr_wr_ready", wr_ready, 1);
            checkOutput("wr_done_early", done, 0);
            applyStimulus(1);
        end
        wr_valid = 1'b0;
        bus_gnt  = 1'b0;
        #1;
        checkOutput("wr_done", done, 1);
        checkOutput("wr_done_req", bus_req, 0);
        checkOutput("wr_done_wr_ready", wr_ready, 0);
        applyStimulus(1);
        #1;
        checkOutput("wr_done_pulse", done, 0);
        checkOutput("wr_back_idle", cmd_ready, 1);

        $display("[TB] read burst 0x200 len 3 with backpressure");
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        cmd_len   = 16'd3;
        bus_gnt   = 1'b1;
        rd_ready  = 1'b0;
        applyStimulus(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("rd_bus_req", bus_req, 1);
            checkOutput("rd_bus_we", bus_we, 0);
            checkOutput("rd_bus_addr", bus_addr, 32'h200 + 32'(4 * i));
            checkOutput("rd_bus_be", bus_be, 4'hF);
            checkOutput("rd_valid_issue", rd_valid, 0);
            applyStimulus(1);
            #1;
            checkOutput("rd_resp_req", bus_req, 0);
            checkOutput("rd_resp_valid", rd_valid, 0);
            applyStimulus(1);
            bus_rvalid = 1'b1;
            bus_rdata  = rdata[i];
            applyStimulus(1);
            bus_rvalid = 1'b0;
            bus_rdata  = 32'hFFFF_FFFF;
            for (int w = 0; w < 5; w++) begin
                #1;
                checkOutput("rd_hold_valid", rd_valid, 1);
                checkOutput("rd_hold_data", rd_data, rdata[i]);
                checkOutput("rd_hold_req", bus_req, 0);
                applyStimulus(1);
            end
            rd_ready = 1'b1;
            #1;
            checkOutput("rd_hs_valid", rd_valid, 1);
            checkOutput("rd_hs_data", rd_data, rdata[i]);
            applyStimulus(1);
            rd_ready = 1'b0;
        end
        bus_gnt = 1'b0;
        #1;
        checkOutput("rd_done", done, 1);
        checkOutput("rd_done_req", bus_req, 0);
        checkOutput("rd_done_valid", rd_valid, 0);
        applyStimulus(1);

        $display("[TB] rvalid ignored in IDLE");
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        applyStimulus(1);
        bus_rvalid = 1'b0;
        #1;
        checkOutput("idle_rvalid_valid", rd_valid, 0);
        checkOutput("idle_rvalid_data", rd_data, rdata[2]);

        $display("[TB] zero length command");
        applyStimulus(1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_len   = 16'd0;
        applyStimulus(1);
        cmd_valid = 1'b0;
        #1;
        checkOutput("zl_done", done, 1);
        checkOutput("zl_bus_req", bus_req, 0);
        checkOutput("zl_busy", busy, 1);
        applyStimulus(1);
        #1;
        checkOutput("zl_done_pulse", done, 0);
        checkOutput("zl_idle", cmd_ready, 1);

        $display("[TB] grant stall of 7 cycles");
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h300;
        cmd_len   = 16'd1;
        wr_valid  = 1'b1;
        wr_data   = 32'hA5A5_5A5A;
        bus_gnt   = 1'b0;
        applyStimulus(1);
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            checkOutput("st_bus_req", bus_req, 1);
            checkOutput("st_bus_addr", bus_addr, 32'h300);
            checkOutput("st_bus_wdata", bus_wdata, 32'hA5A5_5A5A);
            checkOutput("st_bus_we", bus_we, 1);
            checkOutput("st_bus_be", bus_be, 4'hF);
            checkOutput("st_wr_ready", wr_ready, 0);
            applyStimulus(1);
        end
        bus_gnt = 1'b1;
        #1;
`ifdef QRACC_BUS_INIT_PERF_EN
        checkOutput("st_perf", perf_stall_cycles, 7);
`endif
        checkOutput("st_gnt_wr_ready", wr_ready, 1);
        checkOutput("st_gnt_req", bus_req, 1);
        applyStimulus(1);
        wr_valid = 1'b0;
        bus_gnt  = 1'b0;
        #1;
        checkOutput("st_done", done, 1);
        applyStimulus(1);

        $display("[TB] address wrap and mid-burst reset");
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hFFFF_FFFC;
        cmd_len   = 16'd2;
        wr_valid  = 1'b1;
        wr_data   = 32'h0000_0011;
        bus_gnt   = 1'b1;
        applyStimulus(1);
        cmd_valid = 1'b0;
        #1;
        checkOutput("wrap_addr0", bus_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_req0", bus_req, 1);
`ifdef QRACC_BUS_INIT_PERF_EN
        checkOutput("wrap_perf_clear", perf_stall_cycles, 0);
`endif
        applyStimulus(1);
        wr_data = 32'h0000_0022;
        #1;
        checkOutput("wrap_addr1", bus_addr, 32'h0000_0000);
        checkOutput("wrap_req1", bus_req, 1);
        checkOutput("wrap_busy", busy, 1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        #1;
        checkOutput("mr_bus_req", bus_req, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_done", done, 0);
        checkOutput("mr_cmd_ready", cmd_ready, 1);
        checkOutput("mr_wr_ready", wr_ready, 0);
        checkOutput("mr_bus_addr", bus_addr, 0);
        wr_valid = 1'b0;
        bus_gnt  = 1'b0;
        applyStimulus(1);
        #1;
        checkOutput("mr_no_done", done, 0);
        checkOutput("mr_still_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
